// File: rtl/iir_biquad_mc.sv
// Time-shared, multi-channel direct-form-I biquad with a two-stage pipeline.
// Products are registered in stage 1; sum, rounding and saturate/wrap happen in stage 2.
module iir_biquad_mc #(
  parameter int DW       = 11,
  parameter int CW       = 12,
  parameter int FRAC     = 10,
  parameter int NCH      = 4,
  parameter int SAT      = 1,
  parameter int B0_INIT  = 47,
  parameter int B1_INIT  = -14,
  parameter int B2_INIT  = 47,
  parameter int MA1_INIT = 1544,
  parameter int MA2_INIT = -881,
  parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           coef_we,
  input  logic [2:0]     coef_sel,
  input  logic [CW-1:0]  coef_data,
  input  logic           coef_commit,
  input  logic           in_valid,
  input  logic [CHW-1:0] in_ch,
  input  logic [DW-1:0]  x,
  output logic           in_ready,
  output logic           out_valid,
  output logic [CHW-1:0] out_ch,
  output logic [DW-1:0]  y,
  output logic           sat_flag
);

  localparam int PW    = DW + CW;
  localparam int ACCW  = DW + CW + 3;
  localparam int RW    = ACCW - FRAC;
  localparam int NCOEF = 5;

  localparam logic [CHW:0] NCH_LIM = NCH[CHW:0];
  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(1 << (FRAC - 1));
  localparam logic signed [CW-1:0] INIT [NCOEF] = '{
    CW'(B0_INIT), CW'(B1_INIT), CW'(B2_INIT), CW'(MA1_INIT), CW'(MA2_INIT)
  };

  logic signed [CW-1:0] shd_q [NCOEF];
  logic signed [CW-1:0] act_q [NCOEF];

  logic signed [DW-1:0] x1_q [NCH];
  logic signed [DW-1:0] x2_q [NCH];
  logic signed [DW-1:0] y1_q [NCH];
  logic signed [DW-1:0] y2_q [NCH];

  logic                 s1_valid_q;
  logic [CHW-1:0]       s1_ch_q;
  logic signed [PW-1:0] prod_q [NCOEF];
  logic signed [PW-1:0] prod_d [NCOEF];

  logic                 out_valid_q;
  logic [CHW-1:0]       out_ch_q;
  logic signed [DW-1:0] y_q;
  logic                 sat_q;

  logic                   hazard;
  logic                   accept;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_r;
  logic signed [RW-1:0]   rnd;
  logic                   fits;
  logic signed [DW-1:0]   y_d;
  logic                   sat_d;

  function automatic logic signed [PW-1:0] smul(input logic signed [CW-1:0] c,
                                                input logic signed [DW-1:0] d);
    logic signed [PW-1:0] ce;
    logic signed [PW-1:0] de;
    ce = PW'(c);
    de = PW'(d);
    return ce * de;
  endfunction

  // A channel still in stage 1 has not yet written back y1, so it must wait a cycle.
  always_comb begin
    hazard   = s1_valid_q && (s1_ch_q == in_ch);
    in_ready = !hazard && ({1'b0, in_ch} < NCH_LIM) && !clr;
    accept   = in_valid && in_ready;
  end

  always_comb begin
    prod_d[0] = smul(act_q[0], $signed(x));
    prod_d[1] = smul(act_q[1], x1_q[in_ch]);
    prod_d[2] = smul(act_q[2], x2_q[in_ch]);
    prod_d[3] = smul(act_q[3], y1_q[in_ch]);
    prod_d[4] = smul(act_q[4], y2_q[in_ch]);
  end

  always_comb begin
    acc   = ACCW'(prod_q[0]) + ACCW'(prod_q[1]) + ACCW'(prod_q[2])
          + ACCW'(prod_q[3]) + ACCW'(prod_q[4]);
    acc_r = acc + RND_HALF;
    rnd   = RW'(acc_r >>> FRAC);
    fits  = (rnd == RW'($signed(rnd[DW-1:0])));
    sat_d = !fits;
    if (fits || SAT == 0) begin
      y_d = rnd[DW-1:0];
    end else if (rnd[RW-1]) begin
      y_d = {1'b1, {(DW-1){1'b0}}};
    end else begin
      y_d = {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ch_q     <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      y_q         <= '0;
      sat_q       <= 1'b0;
      for (int i = 0; i < NCOEF; i++) prod_q[i] <= '0;
      for (int c = 0; c < NCH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else if (clr) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
      end
    end else begin
      s1_valid_q  <= accept;
      out_valid_q <= s1_valid_q;
      if (accept) begin
        s1_ch_q <= in_ch;
        for (int i = 0; i < NCOEF; i++) prod_q[i] <= prod_d[i];
      end
      if (s1_valid_q) begin
        y_q      <= y_d;
        out_ch_q <= s1_ch_q;
        sat_q    <= sat_d;
      end
      for (int c = 0; c < NCH; c++) begin
        if (accept && in_ch == CHW'(c)) begin
          x2_q[c] <= x1_q[c];
          x1_q[c] <= x;
        end
        if (s1_valid_q && s1_ch_q == CHW'(c)) begin
          y2_q[c] <= y1_q[c];
          y1_q[c] <= y_d;
        end
      end
    end
  end

  // Commit copies the pre-write shadow contents when both happen on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCOEF; i++) begin
        shd_q[i] <= INIT[i];
        act_q[i] <= INIT[i];
      end
    end else begin
      if (coef_we && coef_sel < 3'(NCOEF)) shd_q[coef_sel] <= coef_data;
      if (coef_commit) begin
        for (int i = 0; i < NCOEF; i++) act_q[i] <= shd_q[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign y         = y_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Bench for iir_biquad_mc: directed vector table, hand sequences and random traffic,
// with saturating and wrapping instances checked against an arithmetic reference model.
module tb_iir_biquad_mc;
  localparam int DW  = 11;
  localparam int CW  = 12;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int INIT [5] = '{47, -14, 47, 1544, -881};

  logic clk = 1'b0;
  logic rst, clr, coef_we, coef_commit, in_valid;
  logic [2:0]     coef_sel;
  logic [CW-1:0]  coef_data;
  logic [CHW-1:0] in_ch;
  logic [DW-1:0]  x;

  logic           rdy_s, ov_s, sf_s, rdy_w, ov_w, sf_w;
  logic [CHW-1:0] och_s, och_w;
  logic [DW-1:0]  y_s, y_w;

  always #5 clk = ~clk;

  iir_biquad_mc #(.SAT(1)) dut (
    .clk(clk), .rst(rst), .clr(clr), .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_data(coef_data), .coef_commit(coef_commit), .in_valid(in_valid),
    .in_ch(in_ch), .x(x), .in_ready(rdy_s), .out_valid(ov_s), .out_ch(och_s),
    .y(y_s), .sat_flag(sf_s));

  iir_biquad_mc #(.SAT(0)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .coef_we(coef_we), .coef_sel(coef_sel),
    .coef_data(coef_data), .coef_commit(coef_commit), .in_valid(in_valid),
    .in_ch(in_ch), .x(x), .in_ready(rdy_w), .out_valid(ov_w), .out_ch(och_w),
    .y(y_w), .sat_flag(sf_w));

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state; index 0 = saturating instance, 1 = wrapping instance.
  int m_act [5];
  int m_shd [5];
  int mx1 [NCH];
  int mx2 [NCH];
  int my1 [2][NCH];
  int my2 [2][NCH];
  bit p_v;
  int p_ch;
  int p_y [2];
  bit p_f [2];
  bit o_v;
  int o_ch;
  int o_y [2];
  bit o_f [2];
  bit e_rdy;
  bit rdy_seen;

  typedef struct {
    bit rb; bit v; int ch; int xv; bit we; int sel; int data; bit cm; bit cl;
    bit e_rdy; bit e_ov; bit cy; int e_y; int e_yw; int e_ch; bit e_sat;
  } vec_t;
  vec_t tab[$];

  function automatic vec_t mk(bit rb, bit v, int ch, int xv, bit we, int sel, int data,
                              bit cm, bit cl, bit er, bit eo, bit cy, int ey, int eyw,
                              int ech, bit es);
    vec_t t;
    t.rb = rb; t.v = v; t.ch = ch; t.xv = xv; t.we = we; t.sel = sel; t.data = data;
    t.cm = cm; t.cl = cl; t.e_rdy = er; t.e_ov = eo; t.cy = cy; t.e_y = ey;
    t.e_yw = eyw; t.e_ch = ech; t.e_sat = es;
    return t;
  endfunction

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 5; i++) begin
      m_act[i] = INIT[i];
      m_shd[i] = INIT[i];
    end
    for (int c = 0; c < NCH; c++) begin
      mx1[c] = 0; mx2[c] = 0;
      for (int k = 0; k < 2; k++) begin
        my1[k][c] = 0; my2[k][c] = 0;
      end
    end
    p_v = 0; p_ch = 0; o_v = 0; o_ch = 0;
    for (int k = 0; k < 2; k++) begin
      p_y[k] = 0; p_f[k] = 0; o_y[k] = 0; o_f[k] = 0;
    end
  endfunction

  function automatic void m_calc(int k, int xv, int ch, output int yo, output bit fo);
    longint acc, r;
    acc = longint'(m_act[0]) * xv + longint'(m_act[1]) * mx1[ch]
        + longint'(m_act[2]) * mx2[ch] + longint'(m_act[3]) * my1[k][ch]
        + longint'(m_act[4]) * my2[k][ch];
    r  = (acc + 512) >>> 10;
    fo = (r > 1023) || (r < -1024);
    if (k == 0) begin
      yo = (r > 1023) ? 1023 : (r < -1024) ? -1024 : int'(r);
    end else begin
      yo = int'(r & 2047);
      if (yo >= 1024) yo = yo - 2048;
    end
  endfunction

  function automatic void m_edge(bit v, int ch, int xv, bit we, int sel, int data,
                                 bit cm, bit cl);
    o_v = p_v && !cl;
    if (o_v) begin
      o_ch = p_ch; o_y = p_y; o_f = p_f;
    end
    p_v = 0;
    if (cl) begin
      for (int c = 0; c < NCH; c++) begin
        mx1[c] = 0; mx2[c] = 0;
        for (int k = 0; k < 2; k++) begin
          my1[k][c] = 0; my2[k][c] = 0;
        end
      end
    end
    if (v && e_rdy) begin
      for (int k = 0; k < 2; k++) m_calc(k, xv, ch, p_y[k], p_f[k]);
      mx2[ch] = mx1[ch];
      mx1[ch] = xv;
      for (int k = 0; k < 2; k++) begin
        my2[k][ch] = my1[k][ch];
        my1[k][ch] = p_y[k];
      end
      p_v = 1; p_ch = ch;
    end
    if (cm) m_act = m_shd;
    if (we && sel < 5) m_shd[sel] = data;
  endfunction

  task automatic set_idle();
    in_valid = 0; in_ch = '0; x = '0; coef_we = 0; coef_sel = '0;
    coef_data = '0; coef_commit = 0; clr = 0;
  endtask

  task automatic check_out();
    chk("out_valid", ov_s, o_v);
    chk("out_valid_w", ov_w, o_v);
    if (o_v) begin
      chk("y", sx(y_s), o_y[0]);
      chk("y_w", sx(y_w), o_y[1]);
      chk("out_ch", och_s, o_ch);
      chk("out_ch_w", och_w, o_ch);
      chk("sat_flag", sf_s, o_f[0]);
      chk("sat_flag_w", sf_w, o_f[1]);
    end
  endtask

  task automatic cyc(bit v, int ch, int xv, bit we, int sel, int data, bit cm, bit cl);
    @(negedge clk);
    in_valid = v; in_ch = ch[CHW-1:0]; x = xv[DW-1:0]; coef_we = we;
    coef_sel = sel[2:0]; coef_data = data[CW-1:0]; coef_commit = cm; clr = cl;
    e_rdy = !(p_v && p_ch == ch) && (ch < NCH) && !cl;
    #1;
    rdy_seen = rdy_s;
    chk("in_ready", rdy_s, e_rdy);
    chk("in_ready_w", rdy_w, e_rdy);
    @(posedge clk);
    m_edge(v, ch, xv, we, sel, data, cm, cl);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1;
    m_reset();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    set_idle();
    m_reset();
    @(posedge clk);
    #1;
    chk("rst_out_valid", ov_s, 0);
    chk("rst_y", sx(y_s), 0);
    chk("rst_out_ch", och_s, 0);
    chk("rst_sat", sf_s, 0);
    chk("rst_y_w", sx(y_w), 0);
    chk("rst_in_ready", rdy_s, 1);
    @(negedge clk);
    rst = 0;

    // impulse on ch0 with default coefficients: 5, 6, 9
    tab.push_back(mk(1, 1,0,100, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,0,0,   0,0,0, 0,0, 0, 1,1, 5,5,0,0));
    tab.push_back(mk(0, 1,0,0,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 6,6,0,0));
    tab.push_back(mk(0, 1,0,0,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 9,9,0,0));
    // alternating channels are accepted back to back
    tab.push_back(mk(0, 1,0,3,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,1,5,   0,0,0, 0,0, 1, 1,0, 0,0,0,0));
    tab.push_back(mk(0, 1,0,7,   0,0,0, 0,0, 1, 1,0, 0,0,0,0));
    tab.push_back(mk(0, 1,1,9,   0,0,0, 0,0, 1, 1,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    // saturation / wrap: b0=2047, rest 0
    tab.push_back(mk(1, 0,3,0,   1,0,2047, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   1,1,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   1,2,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   1,3,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   1,4,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 1,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,2,1023, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 1023,-3,2,1));
    tab.push_back(mk(0, 1,3,-1024, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,0,0,   0,0,0, 0,0, 1, 1,1, -1024,1,3,1));
    // commit timing
    tab.push_back(mk(1, 0,3,0,   1,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,0,100, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 5,5,0,0));
    tab.push_back(mk(0, 1,1,100, 0,0,0, 1,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 5,5,1,0));
    tab.push_back(mk(0, 1,2,100, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 1,1, 0,0,2,0));
    tab.push_back(mk(0, 0,0,0,   1,0,47, 1,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,3,100, 0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,0,0,   0,0,0, 0,0, 1, 1,1, 0,0,3,0));
    tab.push_back(mk(0, 0,0,0,   0,0,0, 1,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 1,3,0,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,0,0,   0,0,0, 0,0, 1, 1,1, -1,-1,3,0));
    // clr blocks acceptance
    tab.push_back(mk(0, 1,1,50,  0,0,0, 0,1, 0, 0,0, 0,0,0,0));
    tab.push_back(mk(0, 0,3,0,   0,0,0, 0,0, 1, 0,0, 0,0,0,0));

    foreach (tab[i]) begin
      if (tab[i].rb) do_reset();
      cyc(tab[i].v, tab[i].ch, tab[i].xv, tab[i].we, tab[i].sel, tab[i].data,
          tab[i].cm, tab[i].cl);
      chk($sformatf("tab%0d_ready", i), rdy_seen, tab[i].e_rdy);
      chk($sformatf("tab%0d_out_valid", i), ov_s, tab[i].e_ov);
      if (tab[i].cy) begin
        chk($sformatf("tab%0d_y", i), sx(y_s), tab[i].e_y);
        chk($sformatf("tab%0d_y_w", i), sx(y_w), tab[i].e_yw);
        chk($sformatf("tab%0d_out_ch", i), och_s, tab[i].e_ch);
        chk($sformatf("tab%0d_sat", i), sf_s, tab[i].e_sat);
        chk($sformatf("tab%0d_sat_w", i), sf_w, tab[i].e_sat);
      end
    end

    // channel isolation: impulse on ch1, zeros on all channels round-robin
    do_reset();
    cyc(1, 1, 100, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      cyc(1, (i + 2) % NCH, 0, 0, 0, 0, 0, 0);
      if (o_v && o_ch != 1) chk("iso_zero", sx(y_s), 0);
    end

    // async reset mid-cycle with samples in flight
    cyc(1, 0, 300, 0, 0, 0, 0, 0);
    cyc(1, 2, -200, 0, 0, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_out_valid", ov_s, 0);
    chk("mid_rst_y", sx(y_s), 0);
    chk("mid_rst_sat", sf_s, 0);
    chk("mid_rst_y_w", sx(y_w), 0);
    set_idle();
    m_reset();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) cyc(0, 3, 0, 0, 0, 0, 0, 0);

    // clr zeroes history but keeps committed coefficients
    cyc(0, 3, 0, 1, 0, 200, 0, 0);
    cyc(0, 3, 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 400, 0, 0, 0, 0, 0);
    cyc(1, 1, 400, 0, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 100, 0, 0, 0, 0, 0);
    cyc(0, 3, 0, 0, 0, 0, 0, 0);
    chk("clr_keep_coef_y", sx(y_s), 20);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, NCH - 1),
          $urandom_range(0, 2047) - 1024, $urandom_range(0, 15) == 0,
          $urandom_range(0, 7), $urandom_range(0, 4095) - 2048,
          $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
